// File: rtl/nn_layer_mac.sv
// Fully connected layer neuron engine: one multiply-accumulate per cycle over a latched
// input vector, followed by a shift/clamp activation and a ready/valid result per neuron.
module nn_layer_mac #(
    parameter int N_IN     = 12,
    parameter int N_OUT    = 15,
    parameter int IN_W     = 7,
    parameter int W_W      = 8,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 7,
    parameter int SHIFT    = 6,
    parameter int ACT_MODE = 0,
    parameter int AW       = 8,
    localparam int OIW     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*IN_W-1:0]    in_vec,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [W_W-1:0]          wr_data,
    output logic                    wr_err,
    output logic [OUT_W-1:0]        out_data,
    output logic [OIW-1:0]          out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int NW  = N_IN * N_OUT;
    localparam int WAW = (NW > 1) ? $clog2(NW) : 1;
    localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PW  = IN_W + W_W;
    localparam logic signed [ACC_W-1:0] OMAX = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

    state_t                  state, state_d;
    logic signed [W_W-1:0]   wmem [NW];
    logic signed [W_W-1:0]   bmem [N_OUT];
    logic [N_IN*IN_W-1:0]    vec;
    logic [IW-1:0]           i;
    logic [OIW-1:0]          j;
    logic [OIW-1:0]          jn;
    logic [OIW-1:0]          bidx;
    logic [WAW-1:0]          widx;
    logic signed [ACC_W-1:0] acc;
    logic signed [IN_W-1:0]  x_sel;
    logic signed [W_W-1:0]   w_sel;
    logic signed [W_W-1:0]   b_sel;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] b_ext;
    logic                    hs, last_i, last_j;

    function automatic logic signed [OUT_W-1:0] act(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] t;
        t = a >>> SHIFT;
        if (ACT_MODE == 1 && t < 0)
            t = '0;
        if (t > OMAX)
            t = OMAX;
        else if (t < OMIN)
            t = OMIN;
        return OUT_W'(t);
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign hs       = (state == EMIT) && out_valid && out_ready;
    assign last_i   = (i == IW'(N_IN - 1));
    assign last_j   = (j == OIW'(N_OUT - 1));
    assign jn       = j + OIW'(1);

    // Operand fetch: weight row j is stored contiguously, so the config address doubles as index
    assign widx     = WAW'(32'(j) * N_IN + 32'(i));
    assign x_sel    = vec[i*IN_W +: IN_W];
    assign w_sel    = wmem[widx];
    assign prod     = x_sel * w_sel;
    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    assign bidx     = (state == IDLE) ? '0 : jn;
    assign b_sel    = bmem[bidx];
    assign b_ext    = {{(ACC_W - W_W){b_sel[W_W-1]}}, b_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid) state_d = MAC;
            MAC:     if (last_i) state_d = EMIT;
            EMIT:    if (hs) state_d = last_j ? IDLE : MAC;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++)
                wmem[k] <= '0;
            for (int k = 0; k < N_OUT; k++)
                bmem[k] <= '0;
        end else if (wr_en && state == IDLE) begin
            if (32'(wr_addr) < NW)
                wmem[WAW'(wr_addr)] <= wr_data;
            else if (32'(wr_addr) < NW + N_OUT)
                bmem[OIW'(32'(wr_addr) - NW)] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid)
            vec <= in_vec;
    end

    // Datapath: accumulate during MAC, then one settle cycle in EMIT registers the activation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i         <= '0;
            j         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            wr_err    <= 1'b0;
        end else begin
            wr_err <= wr_en && (state != IDLE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        i   <= '0;
                        j   <= '0;
                        acc <= b_ext;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    i   <= i + IW'(1);
                end
                EMIT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= act(acc);
                        out_idx   <= j;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!last_j) begin
                            j   <= jn;
                            i   <= '0;
                            acc <= b_ext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_mac.sv
// Bench for nn_layer_mac: two instances (linear and ReLU activation) share stimulus and are
// compared against a plain-arithmetic dot-product model of the layer.
module tb_nn_layer_mac;

    localparam int N_IN  = 12;
    localparam int N_OUT = 15;
    localparam int IN_W  = 7;
    localparam int W_W   = 8;
    localparam int OUT_W = 7;
    localparam int AW    = 8;
    localparam int OIW   = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_IN*IN_W-1:0]   in_vec = '0;
    logic                   in_valid = 1'b0;
    logic                   wr_en = 1'b0;
    logic [AW-1:0]          wr_addr = '0;
    logic [W_W-1:0]         wr_data = '0;
    logic                   out_ready = 1'b0;

    logic                   in_ready0, in_ready1, wr_err0, wr_err1;
    logic                   out_valid0, out_valid1, busy0, busy1;
    logic signed [OUT_W-1:0] out_data0, out_data1;
    logic [OIW-1:0]         out_idx0, out_idx1;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int wm[N_OUT][N_IN];
    int bm[N_OUT];
    int xm[N_IN];

    nn_layer_mac #(.ACT_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err0),
        .out_data(out_data0), .out_idx(out_idx0), .out_valid(out_valid0),
        .out_ready(out_ready), .busy(busy0)
    );

    nn_layer_mac #(.ACT_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err1),
        .out_data(out_data1), .out_idx(out_idx1), .out_valid(out_valid1),
        .out_ready(out_ready), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Layer model: dot product plus bias, wrapped to 24 bits, floor-divided by 64, clamped
    function automatic int model(input int j, input int mode);
        longint s;
        longint t;
        s = bm[j];
        for (int k = 0; k < N_IN; k++)
            s += longint'(xm[k]) * longint'(wm[j][k]);
        s = s & 64'hFF_FFFF;
        if (s >= 64'sd8388608)
            s -= 64'sd16777216;
        t = s >>> 6;
        if (mode == 1 && t < 0)
            t = 0;
        if (t > 63)
            t = 63;
        if (t < -64)
            t = -64;
        return int'(t);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int a = 0; a < N_OUT; a++) begin
            bm[a] = 0;
            for (int b = 0; b < N_IN; b++)
                wm[a][b] = 0;
        end
    endtask

    task automatic wr(input int addr, input int data);
        logic [31:0] a32;
        logic [31:0] d32;
        a32 = addr;
        d32 = data;
        wr_en   = 1'b1;
        wr_addr = a32[AW-1:0];
        wr_data = d32[W_W-1:0];
        step();
        wr_en = 1'b0;
        check("wr_err_idle", wr_err0, 0);
        if (addr < N_IN * N_OUT)
            wm[addr / N_IN][addr % N_IN] = data;
        else if (addr < N_IN * N_OUT + N_OUT)
            bm[addr - N_IN * N_OUT] = data;
    endtask

    task automatic load_x();
        logic [31:0] tmp;
        for (int k = 0; k < N_IN; k++) begin
            tmp = xm[k];
            in_vec[k*IN_W +: IN_W] = tmp[IN_W-1:0];
        end
    endtask

    task automatic rand_x();
        for (int k = 0; k < N_IN; k++)
            xm[k] = int'($urandom_range(127)) - 64;
    endtask

    task automatic run(input int stall, input int wbusy, input int abort_j);
        int tref;
        int n;
        load_x();
        check("in_ready_before", in_ready0, 1);
        in_valid = 1'b1;
        step();
        tref = cyc;
        in_vec = {$urandom, $urandom, $urandom};
        if (wbusy != 0) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = 8'd5;
            step();
            wr_en = 1'b0;
            check("wr_err_pulse", wr_err0, 1);
            step();
            check("wr_err_drop", wr_err0, 0);
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (j == abort_j) begin
                repeat (4) step();
                check("busy_in_mac", busy0, 1);
                rst_n = 1'b0;
                #1;
                check("rst_out_valid", out_valid0, 0);
                check("rst_in_ready", in_ready0, 1);
                check("rst_busy", busy0, 0);
                check("rst_out_data", out_data0, 0);
                check("rst_out_idx", out_idx0, 0);
                clear_model();
                step();
                step();
                rst_n = 1'b1;
                step();
                return;
            end
            n = 0;
            while (out_valid0 !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            in_valid = 1'b0;
            check("out_valid", out_valid0, 1);
            check("latency", cyc - tref, N_IN + 1);
            check("out_idx", out_idx0, j);
            check("out_data_lin", out_data0, model(j, 0));
            check("out_data_relu", out_data1, model(j, 1));
            if (stall != 0 && j == 0) begin
                repeat (5) begin
                    step();
                    check("stall_valid", out_valid0, 1);
                    check("stall_idx", out_idx0, 0);
                    check("stall_data", out_data0, model(0, 0));
                end
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            tref = cyc;
            check("valid_drop", out_valid0, 0);
        end
        check("in_ready_after", in_ready0, 1);
    endtask

    initial begin
        clear_model();
        #2;
        check("reset_in_ready", in_ready0, 1);
        check("reset_out_valid", out_valid0, 0);
        check("reset_busy", busy0, 0);
        check("reset_wr_err", wr_err0, 0);
        check("reset_out_data", out_data0, 0);
        check("reset_out_idx", out_idx0, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int a = 0; a < N_IN * N_OUT; a++)
            wr(a, 64);
        for (int a = N_IN * N_OUT; a < N_IN * N_OUT + N_OUT; a++)
            wr(a, 0);
        for (int k = 0; k < N_IN; k++)
            xm[k] = 1;
        run(0, 0, -1);

        for (int a = 0; a < N_IN * N_OUT; a++)
            wr(a, 127);
        for (int k = 0; k < N_IN; k++)
            xm[k] = 63;
        run(0, 0, -1);
        for (int k = 0; k < N_IN; k++)
            xm[k] = -64;
        run(0, 0, -1);

        for (int a = 0; a < N_IN * N_OUT; a++)
            wr(a, 0);
        wr(N_IN * N_OUT + 3, 64);
        rand_x();
        run(1, 0, -1);

        for (int a = 0; a < N_IN * N_OUT + N_OUT; a++)
            wr(a, int'($urandom_range(255)) - 128);
        wr(200, 9);
        wr(255, 1);
        rand_x();
        run(0, 1, -1);
        rand_x();
        run(0, 0, -1);

        rand_x();
        run(0, 0, 2);
        rand_x();
        run(0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nn_layer_mac.md
NN_LAYER_MAC -- requirements
Module: nn_layer_mac

Interface
REQ-001 SHALL have parameter N_IN, default 12, inputs per neuron.
REQ-002 SHALL have parameter N_OUT, default 15, neurons in the layer.
REQ-003 SHALL have parameters IN_W=7, W_W=8, ACC_W=24, OUT_W=7: widths of signed input element, weight/bias, accumulator and output.
REQ-004 SHALL have parameters SHIFT=6 (arithmetic right shift before activation) and ACT_MODE=0 (0 = saturating linear, 1 = ReLU then saturate).
REQ-005 SHALL have parameter AW=8, config address width, with AW >= clog2(N_IN*N_OUT+N_OUT).
REQ-006 Ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-007 Ports: in_vec in N_IN*IN_W, signed input vector, element i at bits [i*IN_W +: IN_W]; in_valid in 1; in_ready out 1.
REQ-008 Ports: wr_en in 1; wr_addr in AW; wr_data in W_W, signed; wr_err out 1, one-cycle pulse.
REQ-009 Ports: out_data out OUT_W, signed activation; out_idx out clog2(N_OUT), neuron index; out_valid out 1; out_ready in 1; busy out 1.

Function
REQ-010 Config map: address a < N_IN*N_OUT SHALL write weight w[a/N_IN][a%N_IN]; N_IN*N_OUT <= a < N_IN*N_OUT+N_OUT SHALL write bias b[a-N_IN*N_OUT]; higher addresses are ignored, with no wr_err.
REQ-011 Writes SHALL take effect only in IDLE; wr_en outside IDLE SHALL leave storage unchanged and pulse wr_err the next cycle.
REQ-012 FSM states SHALL be IDLE, MAC and EMIT; in_ready=1 only in IDLE; busy=1 in MAC and EMIT.
REQ-013 IDLE->MAC on in_valid&&in_ready: latch in_vec, set j=0, i=0, acc=sign-extended b[0].
REQ-014 MAC: each cycle acc += x[i]*w[j][i]; the IN_W+W_W-bit signed product is sign-extended to ACC_W; i increments; after the i=N_IN-1 cycle go to EMIT.
REQ-015 Accumulation SHALL wrap modulo 2^ACC_W; there is no saturation inside the accumulator.
REQ-016 EMIT: out_valid=1, out_idx=j, out_data=act(acc) registered; the values SHALL hold stable until out_ready=1.
REQ-017 act(): t = acc >>> SHIFT; if ACT_MODE=1 and t<0 then t=0; clamp t to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-018 On out_valid&&out_ready with j<N_OUT-1: j++, i=0, acc=b[j+1], go to MAC, out_valid=0 next cycle.
REQ-019 On out_valid&&out_ready with j=N_OUT-1: go to IDLE; in_ready=1 next cycle.
REQ-020 Latency: the first out_valid SHALL occur N_IN+1 cycles after the accepting edge; each later neuron SHALL take N_IN+1 cycles after the previous handshake.
REQ-021 in_valid outside IDLE SHALL be ignored; the latched vector SHALL be unaffected.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, wr_err=0, out_data=0, out_idx=0, acc=0, and all weights and biases to 0, including mid-operation.
REQ-023 After rst_n deasserts, the first accepted vector SHALL start a fresh layer at j=0.

Verification
REQ-024 All w=64, b=0, all x=1, ACT_MODE=0 -> 15 outputs, each out_data=12, out_idx 0..14, first out_valid 13 cycles after acceptance.
REQ-025 All w=127, x=63 -> out_data=63 (clamped); x=-64 -> out_data=-64; ACT_MODE=1 with x=-64 -> out_data=0.
REQ-026 w=0, b[3]=64, others 0 -> out_data=1 at out_idx=3 and 0 elsewhere.
REQ-027 Hold out_ready=0 for 5 cycles at neuron 0 -> out_data, out_idx and out_valid stay constant; neuron 1 appears 13 cycles after the handshake.
REQ-028 wr_en while busy, addr 0, data 5 -> wr_err pulses 1 cycle; the next run shows the weight unchanged.
REQ-029 rst_n low during MAC of neuron 2 -> out_valid=0, in_ready=1 at once; the next run with any x gives out_data=0 for all neurons (storage cleared).
